// File: rtl/h_rocket_launch_manager.sv
// h_rocket_launch_manager: turns fire-key presses into single-rocket launch sequences with flight timeout and frame cooldown
// Ports:
//   clk, resetN (sync, active-low), startOfFrame (frame pulse), clearAll (level restart)
//   fireKey, playerX/playerY (signed 11b), playerFacesLeft: launch request and snapshot source
//   reachedBorder, hitCollision: rocket retirement causes
//   isActive, initialX/initialY/initialSpeed (signed 11b): drive the rocket controller
//   launchPulse (one cycle in LOAD), ready (IDLE), shotCount (saturating launch count)
module h_rocket_launch_manager #(
  parameter int SPEED_MAG         = 256,
  parameter int X_OFFSET_RIGHT    = 32,
  parameter int X_OFFSET_LEFT     = -16,
  parameter int Y_OFFSET          = 8,
  parameter int COOLDOWN_FRAMES   = 15,
  parameter int MAX_FLIGHT_FRAMES = 255
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               clearAll,
  input  logic               fireKey,
  input  logic signed [10:0] playerX,
  input  logic signed [10:0] playerY,
  input  logic               playerFacesLeft,
  input  logic               reachedBorder,
  input  logic               hitCollision,
  output logic               isActive,
  output logic signed [10:0] initialX,
  output logic signed [10:0] initialY,
  output logic signed [10:0] initialSpeed,
  output logic               launchPulse,
  output logic               ready,
  output logic        [15:0] shotCount
);
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, COOLDOWN} state_t;
  state_t state, state_nx;
  logic        fire_d;
  logic [1:0]  blank_cnt;
  logic [7:0]  flight_cnt;
  logic [15:0] cd_cnt;
  logic        fire_edge, hit_exit, timeout, exit_active, cd_done;
  assign fire_edge   = fireKey & ~fire_d;
  // controller position is stale while blank_cnt is nonzero, so border/hit are ignored then
  assign hit_exit    = (blank_cnt == 2'd0) & (reachedBorder | hitCollision);
  assign timeout     = startOfFrame & (flight_cnt == 8'(MAX_FLIGHT_FRAMES - 1));
  assign exit_active = hit_exit | timeout;
  assign cd_done     = (COOLDOWN_FRAMES == 0) | (startOfFrame & (cd_cnt == 16'd0));
  always_ff @(posedge clk)
    if (!resetN) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = fire_edge ? LOAD : IDLE;
      LOAD:     state_nx = ACTIVE;
      ACTIVE:   state_nx = exit_active ? COOLDOWN : ACTIVE;
      COOLDOWN: state_nx = cd_done ? IDLE : COOLDOWN;
    endcase
    if (clearAll) state_nx = IDLE;
  end
  always_comb begin
    isActive    = state == ACTIVE;
    launchPulse = state == LOAD;
    ready       = state == IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetN) begin
      fire_d       <= 1'b0;
      initialX     <= '0;
      initialY     <= '0;
      initialSpeed <= '0;
      shotCount    <= '0;
      blank_cnt    <= '0;
      flight_cnt   <= '0;
      cd_cnt       <= '0;
    end else begin
      fire_d <= fireKey;
      if (state == IDLE && fire_edge && !clearAll) begin
        initialX     <= playerX + (playerFacesLeft ? 11'(X_OFFSET_LEFT) : 11'(X_OFFSET_RIGHT));
        initialY     <= playerY + 11'(Y_OFFSET);
        initialSpeed <= playerFacesLeft ? -11'(SPEED_MAG) : 11'(SPEED_MAG);
      end
      if (state == LOAD && shotCount != 16'hFFFF) shotCount <= shotCount + 16'd1;
      if (clearAll) begin
        blank_cnt  <= '0;
        flight_cnt <= '0;
        cd_cnt     <= '0;
      end else begin
        blank_cnt  <= (state == LOAD) ? 2'd2 :
                      (state == ACTIVE && blank_cnt != 2'd0) ? blank_cnt - 2'd1 : blank_cnt;
        flight_cnt <= (state == LOAD) ? 8'd0 :
                      (state == ACTIVE && startOfFrame && !exit_active) ? flight_cnt + 8'd1 : flight_cnt;
        cd_cnt     <= (state == ACTIVE && exit_active) ? 16'(COOLDOWN_FRAMES) :
                      (state == COOLDOWN && startOfFrame && cd_cnt != 16'd0) ? cd_cnt - 16'd1 : cd_cnt;
      end
    end
  end
endmodule

// File: tb/tb_h_rocket_launch_manager.sv
// tb_h_rocket_launch_manager: scoreboard bench for the rocket launch manager with a phase-level reference model
module tb_h_rocket_launch_manager;
  localparam int MAXF = 255;
  localparam int CD   = 15;
  logic clk = 0, resetN = 0, startOfFrame = 0, clearAll = 0, fireKey = 0;
  logic playerFacesLeft = 0, reachedBorder = 0, hitCollision = 0;
  logic signed [10:0] playerX = 0, playerY = 0;
  logic isActive, launchPulse, ready;
  logic signed [10:0] initialX, initialY, initialSpeed;
  logic [15:0] shotCount;
  int errors = 0, checks = 0;
  h_rocket_launch_manager #(
    .SPEED_MAG(256), .X_OFFSET_RIGHT(32), .X_OFFSET_LEFT(-16), .Y_OFFSET(8),
    .COOLDOWN_FRAMES(CD), .MAX_FLIGHT_FRAMES(MAXF)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .clearAll(clearAll),
    .fireKey(fireKey), .playerX(playerX), .playerY(playerY), .playerFacesLeft(playerFacesLeft),
    .reachedBorder(reachedBorder), .hitCollision(hitCollision), .isActive(isActive),
    .initialX(initialX), .initialY(initialY), .initialSpeed(initialSpeed),
    .launchPulse(launchPulse), .ready(ready), .shotCount(shotCount)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic signed [10:0] x, y, s;
    logic [15:0] shots;
  } rec_t;
  rec_t sb[$];
  rec_t mr;
  // reference model: phase 0 idle, 1 launching, 2 flying, 3 cooling; flight/cooldown tracked as elapsed counts
  int ph = 0, fly_cyc = 0, fly_frm = 0, cool_frm = 0, shots = 0;
  bit kd = 0;
  logic signed [10:0] ex = 0, ey = 0, es = 0;
  task automatic chk(string n, logic [47:0] a, logic [47:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      if (errors < 30) $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_tick();
    bit fe;
    fe = fireKey && !kd;
    kd = fireKey;
    if (!resetN) begin
      ph = 0; kd = 0; shots = 0; ex = 0; ey = 0; es = 0;
    end else if (clearAll) ph = 0;
    else if (ph == 0) begin
      if (fe) begin
        ex = 11'(int'(playerX) + (playerFacesLeft ? -16 : 32));
        ey = 11'(int'(playerY) + 8);
        es = playerFacesLeft ? -11'sd256 : 11'sd256;
        shots = (shots == 65535) ? shots : shots + 1;
        sb.push_back('{ex, ey, es, 16'(shots)});
        ph = 1;
      end
    end else if (ph == 1) begin
      ph = 2; fly_cyc = 0; fly_frm = 0;
    end else if (ph == 2) begin
      if ((fly_cyc >= 2 && (reachedBorder || hitCollision)) || (startOfFrame && fly_frm + 1 == MAXF)) begin
        ph = 3; cool_frm = 0;
      end else begin
        fly_cyc++;
        if (startOfFrame) fly_frm++;
      end
    end else if (CD == 0) ph = 0;
    else if (startOfFrame) begin
      cool_frm++;
      if (cool_frm == CD + 1) ph = 0;
    end
  endtask
  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    chk("cycle_status", {ready, isActive, launchPulse, initialX, initialY, initialSpeed},
        {ph == 0, ph == 2, ph == 1, ex, ey, es});
  endtask
  task automatic frame();
    startOfFrame = 1; step();
    startOfFrame = 0; step();
  endtask
  logic [15:0] pend;
  bit pend_v = 0;
  always @(negedge clk) begin
    if (pend_v) begin
      chk("shot_count", shotCount, pend);
      pend_v = 0;
    end
    if (launchPulse === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL launch_unexpected: got launchPulse=1 expected no launch at %0t", $time);
      end else begin
        mr = sb.pop_front();
        chk("launch_x", initialX, mr.x);
        chk("launch_y", initialY, mr.y);
        chk("launch_speed", initialSpeed, mr.s);
        pend = mr.shots;
        pend_v = 1;
      end
    end
  end
  initial begin
    resetN = 0; step(); step();
    chk("rst_ready", ready, 1);
    chk("rst_active", isActive, 0);
    chk("rst_shots", shotCount, 0);
    chk("rst_initx", initialX, 0);
    resetN = 1; step();
    playerX = 100; playerY = 400; playerFacesLeft = 0; fireKey = 1; step();
    chk("load_pulse", launchPulse, 1);
    chk("load_inactive", isActive, 0);
    chk("init_x_right", initialX, 132);
    chk("init_y", initialY, 408);
    chk("speed_right", initialSpeed, 256);
    step();
    chk("active_rise", isActive, 1);
    chk("shots_1", shotCount, 1);
    reachedBorder = 1; step(); step();
    chk("blank_ignored", isActive, 1);
    step();
    chk("border_exit", isActive, 0);
    reachedBorder = 0;
    repeat (15) frame();
    chk("cd15_not_ready", ready, 0);
    frame();
    chk("cd16_ready", ready, 1);
    repeat (3) step();
    chk("held_no_refire", shotCount, 1);
    chk("held_ready", ready, 1);
    fireKey = 0; step();
    playerX = 5; playerFacesLeft = 1; fireKey = 1; step();
    chk("init_x_left", initialX, -11);
    chk("speed_left", initialSpeed, -256);
    fireKey = 0; step();
    chk("shots_2", shotCount, 2);
    repeat (254) frame();
    chk("pre_timeout", isActive, 1);
    frame();
    chk("timeout_exit", isActive, 0);
    repeat (16) frame();
    chk("after_timeout_idle", ready, 1);
    fireKey = 1; step(); fireKey = 0; step(); step(); step();
    hitCollision = 1; startOfFrame = 1; step();
    chk("hit_sof_exit", isActive, 0);
    hitCollision = 0; startOfFrame = 0;
    repeat (15) frame();
    chk("hit_cd_not_ready", ready, 0);
    frame();
    chk("hit_cd_ready", ready, 1);
    chk("shots_3", shotCount, 3);
    fireKey = 1; step(); fireKey = 0; step(); step();
    clearAll = 1; step();
    chk("clear_inactive", isActive, 0);
    chk("clear_ready", ready, 1);
    chk("clear_keeps_x", initialX, -11);
    chk("clear_keeps_shots", shotCount, 4);
    clearAll = 0;
    fireKey = 1; step(); fireKey = 0; step(); step(); step();
    reachedBorder = 1; step();
    reachedBorder = 0;
    chk("cool_not_ready", ready, 0);
    frame();
    resetN = 0; step();
    chk("midcd_rst_shots", shotCount, 0);
    chk("midcd_rst_x", initialX, 0);
    chk("midcd_rst_ready", ready, 1);
    resetN = 1; step();
    for (int c = 0; c < 20000; c++) begin
      startOfFrame = (c % 4 == 0);
      if ($urandom_range(0, 9) == 0) fireKey = ~fireKey;
      playerX = 11'($urandom);
      playerY = 11'($urandom);
      playerFacesLeft = 1'($urandom);
      reachedBorder = ($urandom_range(0, 59) == 0);
      hitCollision = ($urandom_range(0, 79) == 0);
      clearAll = ($urandom_range(0, 499) == 0);
      step();
    end
    startOfFrame = 0; reachedBorder = 0; hitCollision = 0; fireKey = 0;
    clearAll = 1; step();
    clearAll = 0; repeat (3) step();
    chk("scoreboard_drained", 48'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
